pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_edge_det.sv | 88 ++++++++
 rtl/pwm_capture.sv | 139 +++++++++++++
 tb/tb_pwm_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Optional glitch filter is enabled with macro PWM_CAPTURE_FILTER_EN.
package pwm_pkg;

  localparam int unsigned PWM_DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned PWM_FILTER_DEPTH       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_edge_det.sv
// Input synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN) and
// registered rise/fall detection for the PWM capture block.
module pwm_edge_det
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   lvl;

  // Shift the asynchronous input through the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pwm};
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(PWM_FILTER_DEPTH + 1);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              filt_q, filt_d;

  // Accept a new level only after PWM_FILTER_DEPTH consecutive differing samples
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (fcnt_q == FCNT_W'(PWM_FILTER_DEPTH - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Filter state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  // Compare the clean level with its delayed copy to find edges
  always_comb begin
    prev_d = lvl;
    rise_d = lvl & ~prev_q;
    fall_d = ~lvl & prev_q;
  end

  // Synchronizer and edge registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_level = lvl;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-line timeout.
// Define PWM_CAPTURE_FILTER_EN to insert a glitch filter after the synchronizer.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PWM_DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_pwm,
  input  logic [DATA_WIDTH-1:0] i_timeout,
  output logic [DATA_WIDTH-1:0] o_period,
  output logic [DATA_WIDTH-1:0] o_high,
  output logic                  o_valid,
  output logic                  o_stuck,
  output logic                  o_level
);

  logic rise, fall, level;

  pwm_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pwm   (i_pwm),
    .o_level (level),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  pwm_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [DATA_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [DATA_WIDTH-1:0] hlat_q, hlat_d;
  logic [DATA_WIDTH-1:0] period_q, period_d;
  logic [DATA_WIDTH-1:0] high_q, high_d;
  logic                  valid_q, valid_d;
  logic                  stuck_q, stuck_d;
  logic                  timeout_hit;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v);
    return (&v) ? v : v + DATA_WIDTH'(1);
  endfunction

  // Next-state, counters and capture outputs
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = sat_inc(per_cnt_q);
    edge_cnt_d = sat_inc(edge_cnt_q);
    hlat_d     = hlat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;

    timeout_hit = (i_timeout != '0) && (edge_cnt_q >= i_timeout);

    if (!i_en) begin
      state_d    = IDLE;
      per_cnt_d  = '0;
      edge_cnt_d = '0;
      hlat_d     = '0;
    end else begin
      // Any edge restarts the stuck timer and clears the stuck flag
      if (rise || fall) begin
        edge_cnt_d = DATA_WIDTH'(1);
        stuck_d    = 1'b0;
      end
      if (rise) begin
        per_cnt_d = DATA_WIDTH'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
          end else if (timeout_hit && !fall) begin
            stuck_d = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            hlat_d  = per_cnt_q;
            state_d = LOW;
          end else if (timeout_hit && !rise) begin
            stuck_d = 1'b1;
            state_d = IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = per_cnt_q;
            high_d   = hlat_q;
            valid_d  = 1'b1;
            state_d  = HIGH;
          end else if (timeout_hit && !fall) begin
            stuck_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      edge_cnt_q <= '0;
      hlat_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      hlat_q     <= hlat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_stuck  = stuck_q;
  assign o_level  = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed, table-driven bench for pwm_capture.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FD = PWM_FILTER_DEPTH;
`else
  localparam int unsigned FD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, pwm, pwm4;
  logic [31:0] tmo;
  logic [31:0] o_period, o_high;
  logic        o_valid, o_stuck, o_level;
  logic [3:0]  o_period4, o_high4;
  logic        o_valid4, o_stuck4, o_level4;

  always #5 clk = ~clk;

  pwm_capture #(.DATA_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pwm(pwm), .i_timeout(tmo),
    .o_period(o_period), .o_high(o_high), .o_valid(o_valid),
    .o_stuck(o_stuck), .o_level(o_level)
  );

  pwm_capture #(.DATA_WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pwm(pwm4), .i_timeout(4'(0)),
    .o_period(o_period4), .o_high(o_high4), .o_valid(o_valid4),
    .o_stuck(o_stuck4), .o_level(o_level4)
  );

  typedef struct {
    int unsigned p;
    int unsigned h;
  } rec_t;

  typedef struct {
    int          hi;
    int          lo;
    int          reps;
    int unsigned exp_p;
    int unsigned exp_h;
  } vec_t;

  rec_t        q[$];
  rec_t        q4[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          hold_err = 0;
  logic [31:0] pp = '0, ph = '0;

  // Record every valid pulse and flag output changes without o_valid
  always @(negedge clk) begin
    if (o_valid)  q.push_back('{p: o_period, h: o_high});
    if (o_valid4) q4.push_back('{p: 32'(o_period4), h: 32'(o_high4)});
    if (rst_n && !o_valid && (o_period != pp || o_high != ph)) hold_err++;
    pp = o_period;
    ph = o_high;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    pwm = v;
    cyc(n);
  endtask

  task automatic periods(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    pwm = 1'b0;
    cyc(3);
    q.delete();
    en = 1'b1;
    cyc(1);
  endtask

  vec_t vecs[5];
  int   lat;
  int   qs;
  int   bad;

  initial begin
    vecs[0] = '{hi: 3,  lo: 5,  reps: 4, exp_p: 8,  exp_h: 3};
    vecs[1] = '{hi: 4,  lo: 4,  reps: 3, exp_p: 8,  exp_h: 4};
    vecs[2] = '{hi: 10, lo: 10, reps: 3, exp_p: 20, exp_h: 10};
    vecs[3] = '{hi: 5,  lo: 3,  reps: 4, exp_p: 8,  exp_h: 5};
    vecs[4] = '{hi: 3,  lo: 12, reps: 3, exp_p: 15, exp_h: 3};

    rst_n = 1'b0; en = 1'b0; pwm = 1'b0; pwm4 = 1'b0; tmo = '0;
    cyc(3);
    check("rst_period", o_period, 0);
    check("rst_high",   o_high,   0);
    check("rst_valid",  32'(o_valid), 0);
    check("rst_stuck",  32'(o_stuck), 0);
    check("rst_level",  32'(o_level), 0);
    rst_n = 1'b1;
    cyc(2);

    // Steady patterns: reps rises give reps-1 valid pulses
    for (int i = 0; i < 5; i++) begin
      restart();
      periods(vecs[i].hi, vecs[i].lo, vecs[i].reps);
      drive(1'b0, 12);
      check($sformatf("vec%0d_count", i), 32'(q.size()), 32'(vecs[i].reps - 1));
      foreach (q[k]) begin
        check($sformatf("vec%0d_period%0d", i, k), q[k].p, vecs[i].exp_p);
        check($sformatf("vec%0d_high%0d", i, k),   q[k].h, vecs[i].exp_h);
      end
    end

    // Rise-to-valid latency
    restart();
    periods(4, 4, 1);
    pwm = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(SYNC + 2 + FD));
    drive(1'b1, 3);
    drive(1'b0, 12);

    // Stuck-high timeout
    restart();
    tmo = 32'd20;
    periods(4, 4, 3);
    drive(1'b1, 10);
    check("stuck_early", 32'(o_stuck), 0);
    qs = q.size();
    drive(1'b1, 90);
    check("stuck_set",    32'(o_stuck), 1);
    check("stuck_period", o_period, 8);
    check("stuck_high",   o_high,   4);
    check("stuck_novalid", 32'(q.size()), 32'(qs));
    drive(1'b0, SYNC + FD + 4);
    check("stuck_clear", 32'(o_stuck), 0);
    drive(1'b0, 4);
    tmo = '0;

    // Enable dropped mid-period discards that measurement
    restart();
    periods(4, 4, 3);
    drive(1'b1, 4);
    drive(1'b0, 12);
    q.delete();
    en = 1'b0;
    cyc(4);
    en = 1'b1;
    drive(1'b0, 2);
    periods(4, 4, 3);
    drive(1'b0, 12);
    check("en_count", 32'(q.size()), 2);
    foreach (q[k]) begin
      check($sformatf("en_period%0d", k), q[k].p, 8);
      check($sformatf("en_high%0d", k),   q[k].h, 4);
    end

    // Synchronous reset mid-HIGH
    restart();
    periods(4, 4, 3);
    drive(1'b1, 2);
    rst_n = 1'b0;
    cyc(1);
    check("mrst_period", o_period, 0);
    check("mrst_high",   o_high,   0);
    check("mrst_valid",  32'(o_valid), 0);
    check("mrst_level",  32'(o_level), 0);
    cyc(1);
    q.delete();
    rst_n = 1'b1;
    drive(1'b0, 4);
    periods(4, 4, 3);
    drive(1'b0, 12);
    check("mrst_count", 32'(q.size()), 2);
    foreach (q[k]) begin
      check($sformatf("mrst_period%0d", k), q[k].p, 8);
      check($sformatf("mrst_high%0d", k),   q[k].h, 4);
    end

    // 10/10 PWM with a one-clock low glitch inside each high phase
    restart();
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 4);
      drive(1'b0, 1);
      drive(1'b1, 5);
      drive(1'b0, 10);
    end
    drive(1'b0, 12);
    bad = 0;
    foreach (q[k]) if (q[k].p != 20 || q[k].h != 10) bad++;
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_count", 32'(q.size()), 3);
    check("glitch_bad",   32'(bad), 0);
`else
    check("glitch_corrupts", 32'(bad > 0), 1);
`endif

    // Saturation on the 4-bit instance: 40-clock period
    q4.delete();
    for (int r = 0; r < 3; r++) begin
      pwm4 = 1'b1;
      cyc(20);
      pwm4 = 1'b0;
      cyc(20);
    end
    cyc(12);
    check("sat_count", 32'(q4.size()), 2);
    foreach (q4[k]) begin
      check($sformatf("sat_period%0d", k), q4[k].p, 15);
      check($sformatf("sat_high%0d", k),   q4[k].h, 15);
    end

    check("hold_only_on_valid", 32'(hold_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
